// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } if_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam fetch_entry_t BUBBLE_ENTRY = '{pc: 32'h0, instr: NOP_INSTR};

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer that catches a fetched instruction while IF/ID is stalled.
module if_skid_buf
    import if_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  fetch_entry_t entry_i,
    input  logic         drain_i,
    input  logic         clear_i,
    output logic         valid_o,
    output fetch_entry_t entry_o
);

    logic         valid_r;
    fetch_entry_t entry_r;

    // Clear (redirect) beats load, load beats drain.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_r <= 1'b0;
            entry_r <= BUBBLE_ENTRY;
        end else if (clear_i) begin
            valid_r <= 1'b0;
            entry_r <= BUBBLE_ENTRY;
        end else if (load_i) begin
            valid_r <= 1'b1;
            entry_r <= entry_i;
        end else if (drain_i) begin
            valid_r <= 1'b0;
        end
    end

    assign valid_o = valid_r;
    assign entry_o = entry_r;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over
// req/ack, and presents {pc, instruction, valid} to the IF/ID register.
//
// state  | meaning
// S_IDLE | first cycle after reset, no request yet
// S_WAIT | request outstanding at pc_r, waiting for ack
// S_FULL | skid holds a fetched instruction, no request issued
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] instruction_o,
    output logic        valid_o,
    output logic        flush_o,
    output logic        memStall_o
);

    if_state_t    state_r, state_nxt;
    logic [31:0]  pc_r, pc_nxt;
    logic         pend_r, pend_nxt;
    logic [31:0]  tgt_r, tgt_nxt;

    fetch_entry_t out_r, out_nxt;
    logic         out_valid_r, out_valid_nxt;

    logic         ack_seen;
    logic         accept;
    logic         skid_load, skid_drain, skid_clear;
    logic         skid_valid;
    fetch_entry_t skid_entry;
    fetch_entry_t ack_entry;

    assign ack_seen  = (state_r == S_WAIT) && imem_ack_i;
    // Ack data is dropped when a redirect is pending or arrives this cycle.
    assign accept    = ack_seen && !branch_taken_i && !pend_r;
    assign ack_entry = '{pc: pc_r, instr: imem_data_i};

    if_skid_buf u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (skid_load),
        .entry_i (ack_entry),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .valid_o (skid_valid),
        .entry_o (skid_entry)
    );

    // State, PC and redirect bookkeeping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= S_IDLE;
            pc_r    <= RESET_PC;
            pend_r  <= 1'b0;
            tgt_r   <= 32'h0;
        end else begin
            state_r <= state_nxt;
            pc_r    <= pc_nxt;
            pend_r  <= pend_nxt;
            tgt_r   <= tgt_nxt;
        end
    end

    // Next state, PC update, redirect tracking and skid control.
    always_comb begin
        state_nxt  = state_r;
        pc_nxt     = pc_r;
        pend_nxt   = pend_r;
        tgt_nxt    = tgt_r;
        skid_load  = 1'b0;
        skid_clear = branch_taken_i;
        skid_drain = skid_valid && !stall_i && !branch_taken_i;

        case (state_r)
            S_IDLE: begin
                state_nxt = S_WAIT;
                if (branch_taken_i) begin
                    pc_nxt = branch_target_i;
                end
            end
            S_WAIT: begin
                if (branch_taken_i) begin
                    if (imem_ack_i) begin
                        pc_nxt   = branch_target_i;
                        pend_nxt = 1'b0;
                    end else begin
                        // The request cannot be withdrawn; remember where to go.
                        pend_nxt = 1'b1;
                        tgt_nxt  = branch_target_i;
                    end
                end else if (imem_ack_i) begin
                    if (pend_r) begin
                        pc_nxt   = tgt_r;
                        pend_nxt = 1'b0;
                    end else begin
                        pc_nxt = pc_r + PC_INC;
                        if (stall_i) begin
                            skid_load = 1'b1;
                            state_nxt = S_FULL;
                        end
                    end
                end
            end
            S_FULL: begin
                if (branch_taken_i) begin
                    pc_nxt    = branch_target_i;
                    state_nxt = S_WAIT;
                end else if (!stall_i) begin
                    state_nxt = S_WAIT;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output register source selection: redirect, stall, skid, ack, bubble.
    always_comb begin
        out_nxt       = out_r;
        out_valid_nxt = out_valid_r;
        if (branch_taken_i) begin
            out_nxt       = BUBBLE_ENTRY;
            out_valid_nxt = 1'b0;
        end else if (stall_i) begin
            out_nxt       = out_r;
            out_valid_nxt = out_valid_r;
        end else if (skid_valid) begin
            out_nxt       = skid_entry;
            out_valid_nxt = 1'b1;
        end else if (accept) begin
            out_nxt       = ack_entry;
            out_valid_nxt = 1'b1;
        end else begin
            out_nxt       = BUBBLE_ENTRY;
            out_valid_nxt = 1'b0;
        end
    end

    // IF/ID-facing output register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_r       <= BUBBLE_ENTRY;
            out_valid_r <= 1'b0;
        end else begin
            out_r       <= out_nxt;
            out_valid_r <= out_valid_nxt;
        end
    end

    assign imem_req_o    = (state_r == S_WAIT);
    assign imem_addr_o   = pc_r;
    assign pc_o          = out_r.pc;
    assign instruction_o = out_r.instr;
    assign valid_o       = out_valid_r;
    assign flush_o       = branch_taken_i;
    assign memStall_o    = (state_r == S_IDLE) || ((state_r == S_WAIT) && !imem_ack_i);

    // An ack with no request outstanding is a memory-side protocol error.
    ack_needs_req: assert property (@(posedge clk_i) disable iff (!rst_i)
        imem_ack_i |-> imem_req_o);

    // Skid only fills from an accepted ack, and never while it is already occupied.
    skid_ack_exclusive: assert property (@(posedge clk_i) disable iff (!rst_i)
        !(skid_valid && accept));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: zero/multi-wait memory, stalls, redirects,
// PC wrap and mid-request reset.
module tb_if_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = 32'h0;
    logic [31:0] pc_o;
    logic [31:0] instruction_o;
    logic        valid_o;
    logic        flush_o;
    logic        memStall_o;

    int n_tests = 0;
    int n_fail  = 0;

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .PC_INC(32'd4)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .pc_o            (pc_o),
        .instruction_o   (instruction_o),
        .valid_o         (valid_o),
        .flush_o         (flush_o),
        .memStall_o      (memStall_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] instr_at(input logic [31:0] addr);
        return 32'hC0DE_0000 | {16'h0, addr[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then settle for sampling.
    task automatic cyc(input logic ack, input logic stl, input logic br, input logic [31:0] tgt);
        @(negedge clk_i);
        stall_i         = stl;
        branch_taken_i  = br;
        branch_target_i = tgt;
        imem_ack_i      = ack && imem_req_o;
        imem_data_i     = ack ? instr_at(imem_addr_o) : 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                             input logic v);
        check({tag, ".pc"},    pc_o, pc);
        check({tag, ".instr"}, instruction_o, ins);
        check({tag, ".valid"}, {31'h0, valid_o}, {31'h0, v});
    endtask

    initial begin
        // reset state
        #2;
        check("rst.req", {31'h0, imem_req_o}, 32'h0);
        check("rst.addr", imem_addr_o, 32'h0);
        check_out("rst", 32'h0, 32'h0, 1'b0);
        check("rst.memstall", {31'h0, memStall_o}, 32'h1);

        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("idle.req", {31'h0, imem_req_o}, 32'h0);

        // zero-wait fetch of 0x0, 0x4, then 0x8 with a 3-cycle stall
        cyc(1, 0, 0, 0);
        check("f0.addr", imem_addr_o, 32'h0);
        check("f0.req", {31'h0, imem_req_o}, 32'h1);
        check("f0.memstall", {31'h0, memStall_o}, 32'h0);
        cyc(1, 0, 0, 0);
        check("f4.addr", imem_addr_o, 32'h4);
        check_out("o0", 32'h0, instr_at(32'h0), 1'b1);
        cyc(1, 1, 0, 0);
        check("f8.addr", imem_addr_o, 32'h8);
        check_out("o4", 32'h4, instr_at(32'h4), 1'b1);
        cyc(0, 1, 0, 0);
        check("stall1.req", {31'h0, imem_req_o}, 32'h0);
        check_out("stall1", 32'h4, instr_at(32'h4), 1'b1);
        cyc(0, 1, 0, 0);
        check_out("stall2", 32'h4, instr_at(32'h4), 1'b1);
        cyc(0, 0, 0, 0);
        check("release.req", {31'h0, imem_req_o}, 32'h0);
        check("release.memstall", {31'h0, memStall_o}, 32'h0);
        cyc(0, 0, 0, 0);
        check_out("o8", 32'h8, instr_at(32'h8), 1'b1);
        check("fC.addr", imem_addr_o, 32'hC);
        check("fC.req", {31'h0, imem_req_o}, 32'h1);

        // two-cycle memory latency
        cyc(0, 0, 0, 0);
        check_out("wait", 32'h0, 32'h0, 1'b0);
        check("wait.memstall", {31'h0, memStall_o}, 32'h1);
        cyc(1, 0, 0, 0);
        check("ackC.addr", imem_addr_o, 32'hC);
        check("ackC.memstall", {31'h0, memStall_o}, 32'h0);
        cyc(0, 0, 0, 0);
        check_out("oC", 32'hC, instr_at(32'hC), 1'b1);
        check("f10.addr", imem_addr_o, 32'h10);

        // redirect to 0x100 while 0x10 is outstanding
        cyc(0, 0, 1, 32'h100);
        check("br1.flush", {31'h0, flush_o}, 32'h1);
        check("br1.addr", imem_addr_o, 32'h10);
        cyc(1, 0, 0, 0);
        check("pend.flush", {31'h0, flush_o}, 32'h0);
        check("pend.addr", imem_addr_o, 32'h10);
        check_out("pend", 32'h0, 32'h0, 1'b0);
        cyc(1, 0, 0, 0);
        check("f100.addr", imem_addr_o, 32'h100);
        check_out("discard", 32'h0, 32'h0, 1'b0);

        // two redirects before the pending ack: latest wins
        cyc(0, 0, 1, 32'h100);
        check_out("o100", 32'h100, instr_at(32'h100), 1'b1);
        check("br2.addr", imem_addr_o, 32'h104);
        cyc(0, 0, 1, 32'h200);
        check("br3.addr", imem_addr_o, 32'h104);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("f200.addr", imem_addr_o, 32'h200);
        check_out("discard2", 32'h0, 32'h0, 1'b0);

        // redirect in the same cycle as the pending ack
        cyc(0, 0, 1, 32'h300);
        check("br4.addr", imem_addr_o, 32'h204);
        check_out("o200", 32'h200, instr_at(32'h200), 1'b0 | 1'b1);
        cyc(1, 0, 1, 32'h400);
        cyc(0, 0, 0, 0);
        check("f400.addr", imem_addr_o, 32'h400);

        // redirect with stall while the skid is full
        cyc(1, 1, 0, 0);
        cyc(0, 1, 1, 32'h100);
        check("fullbr.req", {31'h0, imem_req_o}, 32'h0);
        check("fullbr.flush", {31'h0, flush_o}, 32'h1);
        cyc(0, 0, 0, 0);
        check("fullbr.addr", imem_addr_o, 32'h100);
        check("fullbr.req2", {31'h0, imem_req_o}, 32'h1);
        check_out("fullbr", 32'h0, 32'h0, 1'b0);
        cyc(0, 0, 0, 0);
        check_out("skidclr", 32'h0, 32'h0, 1'b0);

        // PC wrap at the top of the address space
        cyc(1, 0, 1, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0);
        check("fwrap.addr", imem_addr_o, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0);
        check("wrap.addr", imem_addr_o, 32'h0);
        check_out("owrap", 32'hFFFF_FFFC, instr_at(32'hFFFF_FFFC), 1'b1);
        cyc(0, 0, 0, 0);
        check("f4b.addr", imem_addr_o, 32'h4);

        // asynchronous reset in the middle of a request
        rst_i = 1'b0;
        #1;
        check("arst.req", {31'h0, imem_req_o}, 32'h0);
        check("arst.addr", imem_addr_o, 32'h0);
        check_out("arst", 32'h0, 32'h0, 1'b0);
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check("rel.memstall", {31'h0, memStall_o}, 32'h1);
        cyc(1, 0, 0, 0);
        check("rel.addr", imem_addr_o, 32'h0);
        check("rel.req", {31'h0, imem_req_o}, 32'h1);
        cyc(0, 0, 0, 0);
        check_out("rel", 32'h0, instr_at(32'h0), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
